// File: rtl/clock_divider.sv
// Timebase divider: emits a registered one-cycle tick every VALUE rising edges of clkIN.
// Phase restarts from zero on every reset release so ticks align to the consumer's start.
module clock_divider #(
    parameter int VALUE = 5,
    parameter int CNT_W = (VALUE > 1) ? $clog2(VALUE) : 1
) (
    input  logic clkIN,
    input  logic nResetIN,
    output logic clkOUT
);

    if (VALUE < 1) begin : g_value_check
        $error("clock_divider: VALUE must be an integer >= 1");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(VALUE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            tick_d = 1'b0;
        end
    end

    // The async clear is the only path from nResetIN to clkOUT.
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign clkOUT = tick_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: VALUE=5 latency/period/reset cases plus VALUE=1 and VALUE=2.
// Inputs change on the falling edge; outputs are sampled 1 ns after each rising edge.
module tb_clock_divider;

    logic clk;
    logic rst5_n, rst1_n, rst2_n;
    logic out5, out1, out2;

    int n_total;
    int n_bad;

    clock_divider #(.VALUE(5)) u_div5 (.clkIN(clk), .nResetIN(rst5_n), .clkOUT(out5));
    clock_divider #(.VALUE(1)) u_div1 (.clkIN(clk), .nResetIN(rst1_n), .clkOUT(out1));
    clock_divider #(.VALUE(2)) u_div2 (.clkIN(clk), .nResetIN(rst2_n), .clkOUT(out2));

    // 50 MHz: rising edges at 10, 30, 50 ns ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks;
        int last;
        int tick_edge [0:25];

        n_total = 0;
        n_bad   = 0;
        rst5_n  = 1'b0;
        rst1_n  = 1'b0;
        rst2_n  = 1'b0;

        // Hold reset three cycles; all outputs must stay low.
        repeat (3) next_edge();
        check_eq("rst_out5", int'(out5), 0);
        check_eq("rst_out1", int'(out1), 0);
        check_eq("rst_out2", int'(out2), 0);

        // Latency: ticks after edges 5,10,15,20 only.
        @(negedge clk);
        rst5_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            next_edge();
            check_eq($sformatf("lat_e%0d", k), int'(out5), (k % 5 == 0) ? 1 : 0);
        end

        // Free-run 1000 cycles from a fresh release: 200 ticks, spacing 5.
        @(negedge clk);
        rst5_n = 1'b0;
        @(negedge clk);
        rst5_n = 1'b1;
        ticks = 0;
        last  = 0;
        for (int k = 1; k <= 1000; k++) begin
            next_edge();
            if (out5) begin
                ticks++;
                check_eq("run_spacing", k - last, 5);
                last = k;
            end
        end
        check_eq("run_ticks", ticks, 200);

        // Async reset mid-pulse, then release at an off-edge phase.
        @(negedge clk);
        rst5_n = 1'b0;
        @(negedge clk);
        rst5_n = 1'b1;
        repeat (5) next_edge();
        check_eq("async_pre", int'(out5), 1);
        #4;
        rst5_n = 1'b0;
        #1;
        check_eq("async_drop", int'(out5), 0);
        #2;
        rst5_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            next_edge();
            check_eq($sformatf("async_e%0d", k), int'(out5), (k == 5) ? 1 : 0);
        end

        // Reset for one cycle while cnt=3; count must restart, not resume.
        @(negedge clk);
        rst5_n = 1'b0;
        @(negedge clk);
        rst5_n = 1'b1;
        repeat (3) next_edge();
        @(negedge clk);
        rst5_n = 1'b0;
        @(negedge clk);
        rst5_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            next_edge();
            check_eq($sformatf("mid_e%0d", k), int'(out5), (k == 5) ? 1 : 0);
        end

        // VALUE=1 always high after first edge; VALUE=2 alternates 0,1.
        @(negedge clk);
        rst1_n = 1'b1;
        rst2_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            next_edge();
            check_eq($sformatf("v1_e%0d", k), int'(out1), 1);
            check_eq($sformatf("v2_e%0d", k), int'(out2), (k % 2 == 0) ? 1 : 0);
        end
        @(negedge clk);
        rst1_n = 1'b0;
        rst2_n = 1'b0;
        #1;
        check_eq("v1_async", int'(out1), 0);

        // Consumer timing: edge number at which the Nth tick appears.
        @(negedge clk);
        rst5_n = 1'b0;
        @(negedge clk);
        rst5_n = 1'b1;
        ticks = 0;
        for (int i = 0; i <= 25; i++) tick_edge[i] = -1;
        for (int k = 1; k <= 130; k++) begin
            next_edge();
            if (out5 && ticks < 25) begin
                ticks++;
                tick_edge[ticks] = k;
            end
        end
        check_eq("tick5_cycle", tick_edge[5], 25);
        check_eq("tick12_cycle", tick_edge[12], 60);
        check_eq("tick25_cycle", tick_edge[25], 125);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
